// File: rtl/shift_sequencer.sv
// Shift-unit sequencer: LOAD -> SHIFT -> DONE handshake between the main
// control FSM and the shift-amount mux / shift register pair.
// Optional build macro: SHIFT_SEQ_ITERATIVE_EN selects single-bit iterative
// shifting (shift_n=1 per step); the default issues one shift of cnt bits.
module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] amt_src,
  input  logic [4:0] amount_in,
  output logic [1:0] shamt_sel,
  output logic [2:0] shift_ctrl,
  output logic [4:0] shift_n,
  output logic       busy,
  output logic       done,
  output logic       wr_en
);

`ifdef SHIFT_SEQ_ITERATIVE_EN
  localparam bit Iterative = 1'b1;
`else
  localparam bit Iterative = 1'b0;
`endif

  localparam logic [2:0] CmdNop  = 3'b000;
  localparam logic [2:0] CmdLoad = 3'b001;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e     state_q;
  logic [1:0] op_q;
  logic [1:0] sel_q;
  logic [4:0] cnt;

  // Shift type to shift-register command.
  function automatic logic [2:0] op_cmd(input logic [1:0] o);
    logic [2:0] c;
    case (o)
      2'b00:   c = 3'b010;
      2'b01:   c = 3'b011;
      2'b10:   c = 3'b100;
      default: c = 3'b101;
    endcase
    return c;
  endfunction

  // The mux select is a register, so it is stable in every state, IDLE included.
  assign shamt_sel = sel_q;

  // Sequencer FSM; outputs are registered as a function of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      sel_q      <= 2'b00;
      cnt        <= 5'd0;
      shift_ctrl <= CmdNop;
      shift_n    <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done    <= 1'b0;
          wr_en   <= 1'b0;
          shift_n <= 5'd0;
          if (start) begin
            state_q    <= StLoad;
            op_q       <= op;
            sel_q      <= amt_src;
            shift_ctrl <= CmdLoad;
            busy       <= 1'b1;
          end else begin
            shift_ctrl <= CmdNop;
            busy       <= 1'b0;
          end
        end
        StLoad: begin
          cnt <= amount_in;
          if (amount_in != 5'd0) begin
            state_q    <= StShift;
            shift_ctrl <= op_cmd(op_q);
            shift_n    <= Iterative ? 5'd1 : amount_in;
          end else begin
            state_q    <= StDone;
            shift_ctrl <= CmdNop;
            shift_n    <= 5'd0;
            done       <= 1'b1;
            wr_en      <= 1'b1;
          end
        end
        StShift: begin
          // Iterative build counts down one step per cycle; exit on the last step.
          if (Iterative) cnt <= cnt - 5'd1;
          if (!Iterative || cnt <= 5'd1) begin
            state_q    <= StDone;
            shift_ctrl <= CmdNop;
            shift_n    <= 5'd0;
            done       <= 1'b1;
            wr_en      <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          shift_ctrl <= CmdNop;
          shift_n    <= 5'd0;
          busy       <= 1'b0;
          done       <= 1'b0;
          wr_en      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; expectations follow the build selected
// by SHIFT_SEQ_ITERATIVE_EN.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_ITERATIVE_EN
  localparam bit Iter = 1'b1;
`else
  localparam bit Iter = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [1:0] amt_src;
  logic [4:0] amount_in;
  logic [1:0] shamt_sel;
  logic [2:0] shift_ctrl;
  logic [4:0] shift_n;
  logic       busy;
  logic       done;
  logic       wr_en;

  int checks   = 0;
  int failures = 0;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amt_src   (amt_src),
    .amount_in (amount_in),
    .shamt_sel (shamt_sel),
    .shift_ctrl(shift_ctrl),
    .shift_n   (shift_n),
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en)
  );

  always #5 clk = ~clk;

  // Pulse start so it is sampled on one edge; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [4:0] a);
    @(negedge clk);
    op = o; amt_src = s; amount_in = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 2'b00; amt_src = 2'b00; amount_in = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({shamt_sel, shift_ctrl, shift_n, busy, done, wr_en} !== 13'd0) begin
      failures++;
      $display("FAIL reset_held outputs=%b want=0", {shamt_sel, shift_ctrl, shift_n, busy, done, wr_en});
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({shamt_sel, shift_ctrl, shift_n, busy, done, wr_en} !== 13'd0) begin
        failures++;
        $display("FAIL reset_idle c=%0d outputs=%b want=0", c,
                 {shamt_sel, shift_ctrl, shift_n, busy, done, wr_en});
      end
    end
  endtask

  // Runs one op from cycle 1 to the cycle after DONE, checking every cycle.
  task automatic test_op(input string name, input logic [1:0] o, input logic [1:0] s,
                         input logic [4:0] a, input logic [2:0] cmd);
    int lat;
    int nshift;
    logic [4:0] n_exp;
    lat    = (a == 5'd0) ? 2 : (Iter ? a + 2 : 3);
    n_exp  = Iter ? 5'd1 : a;
    nshift = 0;
    issue(o, s, a);
    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (shift_ctrl == 3'b010 || shift_ctrl == 3'b011 ||
          shift_ctrl == 3'b100 || shift_ctrl == 3'b101) nshift++;
      checks++;
      if (c == 1) begin
        if ({shift_ctrl, shift_n, busy, done, wr_en} !== {3'b001, 5'd0, 3'b100}) begin
          failures++;
          $display("FAIL %s_load ctrl=%b n=%0d busy=%b done=%b want ctrl=001 n=0 busy=1 done=0",
                   name, shift_ctrl, shift_n, busy, done);
        end
      end else if (c < lat) begin
        if ({shift_ctrl, shift_n, busy, done, wr_en} !== {cmd, n_exp, 3'b100}) begin
          failures++;
          $display("FAIL %s_shift c=%0d ctrl=%b n=%0d busy=%b done=%b want ctrl=%b n=%0d",
                   name, c, shift_ctrl, shift_n, busy, done, cmd, n_exp);
        end
      end else if (c == lat) begin
        if ({shift_ctrl, shift_n, busy, done, wr_en} !== {3'b000, 5'd0, 3'b111}) begin
          failures++;
          $display("FAIL %s_done c=%0d ctrl=%b n=%0d busy=%b done=%b wr_en=%b want done=wr_en=1",
                   name, c, shift_ctrl, shift_n, busy, done, wr_en);
        end
      end else begin
        if ({shift_ctrl, shift_n, busy, done, wr_en} !== {3'b000, 5'd0, 3'b000}) begin
          failures++;
          $display("FAIL %s_idle ctrl=%b busy=%b done=%b want all 0", name, shift_ctrl, busy, done);
        end
      end
      checks++;
      if (shamt_sel !== s) begin
        failures++;
        $display("FAIL %s_sel c=%0d shamt_sel=%b want=%b", name, c, shamt_sel, s);
      end
    end
    checks++;
    if (nshift != ((a == 5'd0) ? 0 : (Iter ? int'(a) : 1))) begin
      failures++;
      $display("FAIL %s_nshift count=%0d want=%0d", name, nshift,
               (a == 5'd0) ? 0 : (Iter ? int'(a) : 1));
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int seen;
    lat = Iter ? 7 : 3;
    issue(2'b01, 2'b10, 5'd5);
    @(negedge clk);                 // cycle 2: SHIFT in both builds
    start = 1'b1;
    @(negedge clk);                 // cycle 3
    start = 1'b0;
    seen = 0;
    for (int c = 3; c <= 20 && seen == 0; c++) begin
      if (done === 1'b1) seen = c;
      else @(negedge clk);
    end
    checks++;
    if (seen != lat) begin
      failures++;
      $display("FAIL b2b_first_done cycle=%0d want=%0d", seen, lat);
    end
    @(negedge clk);                 // IDLE cycle after DONE
    checks++;
    if (busy !== 1'b0 || shift_ctrl !== 3'b000) begin
      failures++;
      $display("FAIL b2b_ignored busy=%b ctrl=%b want busy=0 ctrl=000", busy, shift_ctrl);
    end
    op = 2'b00; amt_src = 2'b11; amount_in = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (shift_ctrl !== 3'b001 || busy !== 1'b1 || shamt_sel !== 2'b11) begin
      failures++;
      $display("FAIL b2b_second_load ctrl=%b busy=%b sel=%b want 001 1 11",
               shift_ctrl, busy, shamt_sel);
    end
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = c + 1;
    end
    checks++;
    if (seen != (Iter ? 4 : 3)) begin
      failures++;
      $display("FAIL b2b_second_done cycle=%0d want=%0d", seen, Iter ? 4 : 3);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bad;
    issue(2'b10, 2'b01, 5'd5);
    @(negedge clk);                 // cycle 2
    if (Iter) @(negedge clk);       // cycle 3: second SHIFT cycle
    checks++;
    if (shift_ctrl !== 3'b100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre ctrl=%b busy=%b want 100 1", shift_ctrl, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({shamt_sel, shift_ctrl, shift_n, busy, done, wr_en} !== 13'd0) begin
      failures++;
      $display("FAIL rstmid_clear outputs=%b want=0", {shamt_sel, shift_ctrl, shift_n, busy, done, wr_en});
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_after bad_cycles=%0d want=0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_op("sll4", 2'b00, 2'b00, 5'd4, 3'b010);
    test_op("sra3", 2'b10, 2'b01, 5'd3, 3'b100);
    test_op("ror0", 2'b11, 2'b10, 5'd0, 3'b101);
    test_op("srl1", 2'b01, 2'b11, 5'd1, 3'b011);
    test_op("ror31", 2'b11, 2'b01, 5'd31, 3'b101);
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
